// File: rtl/regfile_pkg.sv
// Shared register-file definitions used by the writeback arbiter and its round-robin sub-block.
package regfile_pkg;

  localparam int DEFAULT_ADDR_WIDTH = 5;
  localparam int DEFAULT_DATA_WIDTH = 32;

  typedef logic [DEFAULT_ADDR_WIDTH-1:0] reg_idx_t;

  localparam reg_idx_t REG_ZERO = '0;

endpackage

// File: rtl/rr_arbiter.sv
// Rotating-priority arbiter: searches from the pointer upward with wrap, owns the pointer,
// and blanks its grant while reset is held.
module rr_arbiter #(
  parameter int N = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N-1:0]         req,
  input  logic                 advance,
  output logic [N-1:0]         grant,
  output logic [$clog2(N)-1:0] grant_idx
);

  localparam int IDX_W = $clog2(N);

  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [N-1:0]     grant_raw;
  logic             found;

  always_comb begin
    grant_raw = '0;
    grant_idx = '0;
    found     = 1'b0;
    for (int k = 0; k < N; k++) begin
      logic [IDX_W-1:0] idx;
      idx = IDX_W'((int'(ptr_q) + k) % N);
      if (!found && req[idx]) begin
        found          = 1'b1;
        grant_raw[idx] = 1'b1;
        grant_idx      = idx;
      end
    end
  end

  assign grant = reset ? '0 : grant_raw;

  // The winner drops to lowest priority, so a steady requester waits at most N cycles.
  always_comb begin
    ptr_d = ptr_q;
    if (advance) begin
      ptr_d = (grant_idx == IDX_W'(N - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port arbiter: one registered writeback beat per cycle from NUM_REQ sources.
// Define REGFILE_WB_SCOREBOARD_EN to add the pending-write scoreboard and its issue/operand ports.
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int NUM_REQ    = 3,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic                          CLK,
  input  logic                          RESET,
  input  logic [NUM_REQ-1:0]            REQ_VALID,
  output logic [NUM_REQ-1:0]            REQ_READY,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] REQ_RD,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] REQ_DATA,
  output logic                          WEN,
  output logic [ADDR_WIDTH-1:0]         RD_SEL,
  output logic [DATA_WIDTH-1:0]         WB_DATA,
  output logic [$clog2(NUM_REQ)-1:0]    GRANT_ID
`ifdef REGFILE_WB_SCOREBOARD_EN
  ,
  input  logic                          ISSUE_VALID,
  input  logic [ADDR_WIDTH-1:0]         ISSUE_RD,
  input  logic [ADDR_WIDTH-1:0]         RS1_SEL,
  input  logic [ADDR_WIDTH-1:0]         RS2_SEL,
  output logic                          RS1_BUSY,
  output logic                          RS2_BUSY
`endif
);

  localparam int IDX_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]    grant;
  logic [IDX_W-1:0]      grant_idx;
  logic                  transfer;
  logic [ADDR_WIDTH-1:0] sel_rd;
  logic [DATA_WIDTH-1:0] sel_data;

  logic                  wen_q, wen_d;
  logic [ADDR_WIDTH-1:0] rd_sel_q, rd_sel_d;
  logic [DATA_WIDTH-1:0] wb_data_q, wb_data_d;
  logic [IDX_W-1:0]      grant_id_q, grant_id_d;

  rr_arbiter #(.N(NUM_REQ)) u_rr_arbiter (
    .clk       (CLK),
    .reset     (RESET),
    .req       (REQ_VALID),
    .advance   (transfer),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  assign REQ_READY = grant;
  assign transfer  = |grant;

  always_comb begin
    sel_rd   = '0;
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_rd   = REQ_RD[i*ADDR_WIDTH +: ADDR_WIDTH];
        sel_data = REQ_DATA[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Writes to x0 are still consumed, but never reach the register file as a write enable.
  always_comb begin
    wen_d      = transfer && (sel_rd != ADDR_WIDTH'(REG_ZERO));
    rd_sel_d   = transfer ? sel_rd    : rd_sel_q;
    wb_data_d  = transfer ? sel_data  : wb_data_q;
    grant_id_d = transfer ? grant_idx : grant_id_q;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      wen_q      <= 1'b0;
      rd_sel_q   <= '0;
      wb_data_q  <= '0;
      grant_id_q <= '0;
    end else begin
      wen_q      <= wen_d;
      rd_sel_q   <= rd_sel_d;
      wb_data_q  <= wb_data_d;
      grant_id_q <= grant_id_d;
    end
  end

  assign WEN      = wen_q;
  assign RD_SEL   = rd_sel_q;
  assign WB_DATA  = wb_data_q;
  assign GRANT_ID = grant_id_q;

`ifdef REGFILE_WB_SCOREBOARD_EN
  localparam int SB_ENTRIES = 32;

  logic [SB_ENTRIES-1:0] pending_q, pending_d;

  // Set is applied after clear so a newer producer of the same register stays pending.
  always_comb begin
    pending_d = pending_q;
    if (wen_q) begin
      pending_d[rd_sel_q] = 1'b0;
    end
    if (ISSUE_VALID && (ISSUE_RD != ADDR_WIDTH'(REG_ZERO))) begin
      pending_d[ISSUE_RD] = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
    end
  end

  assign RS1_BUSY = (RS1_SEL != ADDR_WIDTH'(REG_ZERO)) && pending_q[RS1_SEL];
  assign RS2_BUSY = (RS2_SEL != ADDR_WIDTH'(REG_ZERO)) && pending_q[RS2_SEL];
`endif

endmodule
